// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared widths, word layout and feeder state encoding for the switch ports
package switch_pkg;

  localparam int PORT_DATA_W = 16;
  localparam int PORT_ADDR_W = 16;
  localparam int NUM_PORTS   = 4;

  typedef struct packed {
    logic [PORT_ADDR_W-1:0] addr;
    logic [PORT_DATA_W-1:0] data;
  } port_word_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } feeder_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/switch_port_feeder_if.sv
// rtl/switch_port_feeder_if.sv - upstream push stream plus the per-port switch write slice
interface switch_port_feeder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr_in;
  logic              wr_en;
  logic              data_rcv;

  modport slave (
    input  s_valid, s_data, s_addr, data_rcv,
    output s_ready, data_in, addr_in, wr_en
  );

  modport master (
    output s_valid, s_data, s_addr, data_rcv,
    input  s_ready, data_in, addr_in, wr_en
  );

endinterface

// File: rtl/switch_port_feeder_fifo.sv
// rtl/switch_port_feeder_fifo.sv - synchronous word buffer exposing the head and the entry behind it
module feeder_fifo
  import switch_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type word_t = port_word_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  word_t                    wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output word_t                    head,
  output word_t                    next
);

  localparam int PW = $clog2(DEPTH);

  word_t           mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
  assign next  = mem_q[rd_ptr_q + PW'(1)];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/switch_port_feeder.sv
// rtl/switch_port_feeder.sv - buffers pushed words and presents them to one switch port until acked or timed out
module switch_port_feeder
  import switch_pkg::*;
#(
  parameter int DATA_W  = PORT_DATA_W,
  parameter int ADDR_W  = PORT_ADDR_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  switch_port_feeder_if.slave  bus,
  output logic                 drop_pulse,
  output logic [15:0]          sent_cnt,
  output logic [15:0]          drop_cnt
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } word_t;

  word_t           push_word, fifo_head, fifo_next;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]   fifo_count;

  feeder_state_t   state_q, state_d;
  logic            wr_en_q, wr_en_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            drop_q, drop_d;
  logic [15:0]     sent_q, sent_d;
  logic [15:0]     dropc_q, dropc_d;

  assign push_word.addr = bus.s_addr;
  assign push_word.data = bus.s_data;

  feeder_fifo #(
    .DEPTH  (DEPTH),
    .word_t (word_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.s_valid),
    .pop   (fifo_pop),
    .wdata (push_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head),
    .next  (fifo_next)
  );

  assign bus.s_ready = !fifo_full;
  assign bus.wr_en   = wr_en_q;
  assign bus.data_in = data_q;
  assign bus.addr_in = addr_q;
  assign drop_pulse  = drop_q;
  assign sent_cnt    = sent_q;
  assign drop_cnt    = dropc_q;

  always_comb begin
    state_d  = state_q;
    wr_en_d  = wr_en_q;
    data_d   = data_q;
    addr_d   = addr_q;
    tmo_d    = tmo_q;
    drop_d   = 1'b0;
    sent_d   = sent_q;
    dropc_d  = dropc_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !fifo_empty) begin
          data_d  = fifo_head.data;
          addr_d  = fifo_head.addr;
          wr_en_d = 1'b1;
          tmo_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.data_rcv) begin
          fifo_pop = 1'b1;
          sent_d   = sat_inc(sent_q);
          tmo_d    = '0;
          // The head is popping this edge, so the entry behind it becomes the next word.
          if (en && fifo_count >= CW'(2)) begin
            data_d = fifo_next.data;
            addr_d = fifo_next.addr;
          end else begin
            wr_en_d = 1'b0;
            state_d = IDLE;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          fifo_pop = 1'b1;
          dropc_d  = sat_inc(dropc_q);
          drop_d   = 1'b1;
          wr_en_d  = 1'b0;
          tmo_d    = '0;
          state_d  = GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      tmo_q   <= '0;
      drop_q  <= 1'b0;
      sent_q  <= '0;
      dropc_q <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
      sent_q  <= sent_d;
      dropc_q <= dropc_d;
    end
  end

endmodule

// File: tb/tb_switch_port_feeder.sv
// tb/tb_switch_port_feeder.sv - directed and randomized checks of switch_port_feeder against a queue model
module tb_switch_port_feeder;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        drop_pulse;
  logic [15:0] sent_cnt;
  logic [15:0] drop_cnt;

  switch_port_feeder_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  switch_port_feeder #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .bus        (bus),
    .drop_pulse (drop_pulse),
    .sent_cnt   (sent_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_q[$];
  bit          m_valid = 0;
  bit          m_wr    = 0;
  bit          m_gap   = 0;
  bit          m_dpul  = 0;
  int          m_wait  = 0;
  logic [15:0] m_sent  = '0;
  logic [15:0] m_drop  = '0;
  int          wr_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit          rs, acc, drp, psh;
    int          sz;
    logic [31:0] hd;
    rs = reset;
    if (m_valid && !rs) begin
      chk("s_ready", 32'(bus.s_ready), 32'(m_q.size() < DEPTH));
      chk("wr_en", 32'(bus.wr_en), 32'(m_wr));
      if (bus.wr_en) wr_cycles++;
      if (m_wr && m_q.size() > 0) begin
        hd = m_q[0];
        chk("data_in", 32'(bus.data_in), 32'(hd[15:0]));
        chk("addr_in", 32'(bus.addr_in), 32'(hd[31:16]));
      end
    end
    if (rs) begin
      m_q.delete();
      m_valid = 1; m_wr = 0; m_gap = 0; m_dpul = 0; m_wait = 0;
      m_sent = '0; m_drop = '0;
    end else if (m_valid) begin
      sz  = m_q.size();
      acc = m_wr && bus.data_rcv;
      drp = m_wr && !bus.data_rcv && (m_wait == TIMEOUT - 1);
      psh = bus.s_valid && (sz < DEPTH);
      m_dpul = drp;
      if (acc) begin
        if (m_sent != 16'hFFFF) m_sent++;
        m_wait = 0;
        m_wr   = en && (sz >= 2);
      end else if (drp) begin
        if (m_drop != 16'hFFFF) m_drop++;
        m_wait = 0;
        m_wr   = 0;
        m_gap  = 1;
      end else if (m_wr) begin
        m_wait++;
      end else if (m_gap) begin
        m_gap = 0;
      end else if (en && sz > 0) begin
        m_wr   = 1;
        m_wait = 0;
      end
      if (acc || drp) void'(m_q.pop_front());
      if (psh) m_q.push_back({bus.s_addr, bus.s_data});
    end
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("drop_pulse", 32'(drop_pulse), 32'(m_dpul));
      chk("sent_cnt", 32'(sent_cnt), 32'(m_sent));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (rs) begin
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_data_in", 32'(bus.data_in), 32'd0);
        chk("rst_addr_in", 32'(bus.addr_in), 32'd0);
      end
    end
  endtask

  task automatic push_word(input logic [15:0] a, input logic [15:0] d);
    bus.s_valid = 1'b1;
    bus.s_addr  = a;
    bus.s_data  = d;
    tick();
    bus.s_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    int run, best;
    reset = 1'b1; en = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_addr = '0; bus.data_rcv = 1'b0;
    #1;
    tick(); tick();
    reset = 1'b0;

    // Reset in the middle of a transfer with three words buffered
    en = 1'b1;
    push_word(16'h0010, 16'h1111);
    push_word(16'h0011, 16'h2222);
    push_word(16'h0012, 16'h3333);
    tick(); tick();
    chk("pre_reset_wr_en", 32'(bus.wr_en), 32'd1);
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    chk("post_reset_ready", 32'(bus.s_ready), 32'd1);
    chk("post_reset_sent", 32'(sent_cnt), 32'd0);
    tick(); tick(); tick();
    chk("post_reset_idle", 32'(bus.wr_en), 32'd0);

    // Single word with data_rcv tied high
    bus.data_rcv = 1'b1;
    wr_cycles = 0;
    push_word(16'h0002, 16'hA5A5);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.wr_en && !seen) begin
        seen = 1;
        chk("single_data", 32'(bus.data_in), 32'h0000A5A5);
        chk("single_addr", 32'(bus.addr_in), 32'h00000002);
      end
      tick();
    end
    chk("single_seen", 32'(seen), 32'd1);
    chk("single_wr_cycles", 32'(wr_cycles), 32'd1);
    chk("single_sent", 32'(sent_cnt), 32'd1);

    // Back-to-back: fill with en low, then release
    en = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(16'(i), 16'(i));
    chk("full_ready", 32'(bus.s_ready), 32'd0);
    push_word(16'h00FF, 16'hDEAD);
    en = 1'b1;
    run = 0; best = 0; wr_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.wr_en) begin run++; if (run > best) best = run; end else run = 0;
    end
    chk("b2b_run", 32'(best), 32'd4);
    chk("b2b_sent", 32'(sent_cnt), 32'd5);

    // Stall for five cycles, then acknowledge
    bus.data_rcv = 1'b0;
    push_word(16'h0030, 16'hBEEF);
    tick();
    chk("stall_wr_en", 32'(bus.wr_en), 32'd1);
    wr_cycles = 0;
    for (int i = 0; i < 5; i++) tick();
    bus.data_rcv = 1'b1;
    tick();
    bus.data_rcv = 1'b0;
    chk("stall_wr_cycles", 32'(wr_cycles), 32'd6);
    chk("stall_sent", 32'(sent_cnt), 32'd6);
    chk("stall_drop", 32'(drop_cnt), 32'd0);

    // Timeout drop, then a word acknowledged on its last allowed cycle
    wr_cycles = 0;
    push_word(16'h0040, 16'h4040);
    push_word(16'h0041, 16'h4141);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (drop_pulse) seen = 1;
    end
    chk("tmo_seen", 32'(seen), 32'd1);
    chk("tmo_wr_cycles", 32'(wr_cycles), 32'(TIMEOUT));
    chk("tmo_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("tmo_low1", 32'(bus.wr_en), 32'd0);
    tick();
    chk("tmo_low2", 32'(bus.wr_en), 32'd0);
    tick();
    chk("tmo_next", 32'(bus.wr_en), 32'd1);
    chk("tmo_next_data", 32'(bus.data_in), 32'h00004141);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    bus.data_rcv = 1'b1;
    tick();
    bus.data_rcv = 1'b0;
    chk("tmo_edge_sent", 32'(sent_cnt), 32'd7);
    chk("tmo_edge_drop", 32'(drop_cnt), 32'd1);

    // Enable gating
    en = 1'b0;
    push_word(16'h0050, 16'h5050);
    push_word(16'h0051, 16'h5151);
    wr_cycles = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("en_off_wr", 32'(wr_cycles), 32'd0);
    en = 1'b1; bus.data_rcv = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("en_on_sent", 32'(sent_cnt), 32'd9);

    // Randomized traffic, alternating responsive and sluggish switch phases
    for (int i = 0; i < 800; i++) begin
      bus.s_valid  = ($urandom_range(0, 2) != 0);
      bus.s_data   = 16'($urandom);
      bus.s_addr   = 16'($urandom_range(0, 3));
      en           = ($urandom_range(0, 7) != 0);
      bus.data_rcv = ((i / 100) % 2 == 0) ? ($urandom_range(0, 1) == 1)
                                           : ($urandom_range(0, 19) == 0);
      tick();
    end

    // Saturation of sent_cnt
    reset = 1'b1; bus.s_valid = 1'b0;
    tick();
    reset = 1'b0;
    en = 1'b1; bus.data_rcv = 1'b1; bus.s_valid = 1'b1;
    for (int i = 0; i < 70000 && m_sent < 16'hFFFE; i++) begin
      bus.s_data = 16'($urandom);
      tick();
    end
    chk("sat_reach", 32'(sent_cnt), 32'h0000FFFE);
    for (int i = 0; i < 6; i++) tick();
    bus.s_valid = 1'b0;
    chk("sat_hold", 32'(sent_cnt), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
